// File: rtl/gsu_cache_ctrl.sv
// GSU 512-byte instruction cache sequencer: hit lookup, 16-byte line fills, cache bypass,
// line-valid flags, cache base register and BRAM write-port sharing with SNES MMIO writes.
module gsu_cache_ctrl #(
  parameter int LINE_BYTES = 16,
  parameter int NUM_LINES  = 32
) (
  input  logic        clkin,
  input  logic        rst_n,
  input  logic [15:0] cbr_in,
  input  logic        cbr_we,
  input  logic        flush,
  output logic [15:0] cbr,
  input  logic        fetch_req,
  input  logic [7:0]  fetch_pbr,
  input  logic [15:0] fetch_addr,
  output logic        fetch_ack,
  output logic [7:0]  fetch_data,
  output logic        mem_req,
  output logic [23:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_data,
  output logic [8:0]  cache_raddr,
  input  logic [7:0]  cache_rdata,
  output logic        cache_we,
  output logic [8:0]  cache_waddr,
  output logic [7:0]  cache_wdata,
  input  logic        snes_wr,
  input  logic [8:0]  snes_addr,
  input  logic [7:0]  snes_data,
  output logic [31:0] valid_flags,
  output logic [2:0]  dbg_state
);

  localparam int CACHE_BYTES = LINE_BYTES * NUM_LINES;

  // Handshakes: fetch_req and mem_req are held high until their acknowledge; fetch_ack and
  // mem_ack are single-cycle pulses qualifying their data, and a request is only sampled in IDLE.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HIT  = 3'd1,
    S_FILL = 3'd2,
    S_FWR  = 3'd3,
    S_BYP  = 3'd4,
    S_BACK = 3'd5
  } state_t;

  state_t      state_q;
  logic [15:0] cbr_q;
  logic [31:0] flags_q, flags_d;
  logic [4:0]  line_q;
  logic [3:0]  beat_q;
  logic [11:0] base_q;
  logic [7:0]  pbr_q;
  logic [15:0] addr_q;
  logic [7:0]  wbuf_q;
  logic        abort_q;

  logic [15:0] off;
  logic [4:0]  line;
  logic        in_win, inval, lookup, fill_wr;

  assign off    = fetch_addr - cbr_q;
  assign line   = off[8:4];
  assign in_win = off < 16'(CACHE_BYTES);
  assign inval  = flush | cbr_we;
  // An invalidation in IDLE defers the lookup so it is made against the new base and cleared flags.
  assign lookup  = (state_q == S_IDLE) && fetch_req && !inval;
  assign fill_wr = (state_q == S_FWR) && !snes_wr && !abort_q && !inval;

  assign cbr         = cbr_q;
  assign valid_flags = flags_q;
  assign dbg_state   = state_q;
  assign cache_raddr = (lookup && in_win) ? off[8:0] : 9'd0;
  assign cache_we    = snes_wr | fill_wr;
  assign cache_waddr = snes_wr ? snes_addr : (fill_wr ? {line_q, beat_q} : 9'd0);
  assign cache_wdata = snes_wr ? snes_data : (fill_wr ? wbuf_q : 8'd0);
  assign mem_req     = (state_q == S_FILL) || (state_q == S_BYP);
  assign fetch_ack   = (state_q == S_HIT) || (state_q == S_BACK);

  always_comb begin
    mem_addr   = 24'd0;
    fetch_data = 8'd0;
    case (state_q)
      S_FILL:  mem_addr = {pbr_q, base_q, beat_q};
      S_BYP:   mem_addr = {pbr_q, addr_q};
      S_HIT:   fetch_data = cache_rdata;
      S_BACK:  fetch_data = wbuf_q;
      default: ;
    endcase
  end

  always_comb begin
    flags_d = flags_q;
    if (snes_wr && snes_addr[3:0] == 4'hF) flags_d[snes_addr[8:4]] = 1'b1;
    if (fill_wr && beat_q == 4'hF) flags_d[line_q] = 1'b1;
    if (inval) flags_d = '0;
  end

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cbr_q   <= 16'd0;
      flags_q <= 32'd0;
      line_q  <= 5'd0;
      beat_q  <= 4'd0;
      base_q  <= 12'd0;
      pbr_q   <= 8'd0;
      addr_q  <= 16'd0;
      wbuf_q  <= 8'd0;
      abort_q <= 1'b0;
    end else begin
      if (cbr_we) cbr_q <= cbr_in & 16'hFFF0;
      flags_q <= flags_d;
      case (state_q)
        S_IDLE: begin
          if (lookup) begin
            pbr_q   <= fetch_pbr;
            addr_q  <= fetch_addr;
            line_q  <= line;
            // Line base is latched so a base change mid-fill cannot move an outstanding beat.
            base_q  <= cbr_q[15:4] + {7'd0, line};
            beat_q  <= 4'd0;
            abort_q <= 1'b0;
            if (!in_win)            state_q <= S_BYP;
            else if (flags_q[line]) state_q <= S_HIT;
            else                    state_q <= S_FILL;
          end
        end
        S_HIT:  state_q <= S_IDLE;
        S_BACK: state_q <= S_IDLE;
        S_BYP: begin
          if (mem_ack) begin
            wbuf_q  <= mem_data;
            state_q <= S_BACK;
          end
        end
        S_FILL: begin
          if (mem_ack) begin
            wbuf_q <= mem_data;
            if (abort_q || inval) begin
              abort_q <= 1'b0;
              state_q <= S_IDLE;
            end else begin
              state_q <= S_FWR;
            end
          end else if (inval) begin
            abort_q <= 1'b1;
          end
        end
        S_FWR: begin
          if (abort_q || inval) begin
            abort_q <= 1'b0;
            state_q <= S_IDLE;
          end else if (!snes_wr) begin
            if (beat_q == 4'hF) begin
              state_q <= S_IDLE;
            end else begin
              beat_q  <= beat_q + 4'd1;
              state_q <= S_FILL;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gsu_cache_ctrl.sv
// Self-checking bench for gsu_cache_ctrl: directed scenarios plus randomized fetches,
// scored against a line-level model of the cache (flags, contents, base, bus traffic).
module tb_gsu_cache_ctrl;

  logic        clkin = 1'b0;
  logic        rst_n;
  logic [15:0] cbr_in;
  logic        cbr_we, flush;
  logic [15:0] cbr;
  logic        fetch_req;
  logic [7:0]  fetch_pbr;
  logic [15:0] fetch_addr;
  logic        fetch_ack;
  logic [7:0]  fetch_data;
  logic        mem_req;
  logic [23:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_data;
  logic [8:0]  cache_raddr;
  logic [7:0]  cache_rdata;
  logic        cache_we;
  logic [8:0]  cache_waddr;
  logic [7:0]  cache_wdata;
  logic        snes_wr;
  logic [8:0]  snes_addr;
  logic [7:0]  snes_data;
  logic [31:0] valid_flags;
  logic [2:0]  dbg_state;

  gsu_cache_ctrl dut (
    .clkin(clkin), .rst_n(rst_n), .cbr_in(cbr_in), .cbr_we(cbr_we), .flush(flush), .cbr(cbr),
    .fetch_req(fetch_req), .fetch_pbr(fetch_pbr), .fetch_addr(fetch_addr),
    .fetch_ack(fetch_ack), .fetch_data(fetch_data),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
    .cache_raddr(cache_raddr), .cache_rdata(cache_rdata), .cache_we(cache_we),
    .cache_waddr(cache_waddr), .cache_wdata(cache_wdata),
    .snes_wr(snes_wr), .snes_addr(snes_addr), .snes_data(snes_data),
    .valid_flags(valid_flags), .dbg_state(dbg_state)
  );

  always #5 clkin = ~clkin;

  logic [7:0]  bram [512] = '{default: 8'h00};
  logic [7:0]  m_cache [512] = '{default: 8'h00};
  logic [31:0] m_flags;
  logic [15:0] m_cbr;
  logic [23:0] obs_q[$];
  logic [23:0] exp_q[$];
  logic [16:0] wr_q[$];
  logic [16:0] exp_wr_q[$];
  int n_chk = 0;
  int n_pass = 0;
  int ack_gap = 1;
  int gap_cnt = 0;
  int acks = 0;

  // External cache BRAM: synchronous read, write at the clock edge; every write is logged.
  always @(posedge clkin) begin
    cache_rdata <= bram[cache_raddr];
    if (cache_we) begin
      bram[cache_waddr] <= cache_wdata;
      wr_q.push_back({cache_waddr, cache_wdata});
    end
  end

  function automatic logic [7:0] bus_byte(input logic [23:0] a);
    return a[7:0] ^ a[23:16];
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One clock: clear pulses, then play the memory bus (ack after ack_gap idle cycles).
  task automatic tick();
    @(negedge clkin);
    flush = 1'b0;
    cbr_we = 1'b0;
    snes_wr = 1'b0;
    mem_ack = 1'b0;
    if (mem_req) begin
      if (gap_cnt <= 0) begin
        mem_ack = 1'b1;
        mem_data = bus_byte(mem_addr);
        obs_q.push_back(mem_addr);
        acks++;
        gap_cnt = (ack_gap < 0) ? int'($urandom_range(0, 3)) : ack_gap;
      end else begin
        gap_cnt--;
      end
    end
  endtask

  task automatic set_cbr(input logic [15:0] v);
    tick();
    cbr_we = 1'b1;
    cbr_in = v;
    tick();
    m_cbr = v & 16'hFFF0;
    m_flags = 32'd0;
    check("cbr_load", cbr, m_cbr);
    check("cbr_flags", valid_flags, m_flags);
  endtask

  task automatic do_flush();
    tick();
    flush = 1'b1;
    tick();
    m_flags = 32'd0;
    check("flush_flags", valid_flags, m_flags);
  endtask

  task automatic snes_write(input logic [8:0] a, input logic [7:0] d);
    tick();
    snes_wr = 1'b1;
    snes_addr = a;
    snes_data = d;
    wr_q.delete();
    tick();
    m_cache[a] = d;
    if (a[3:0] == 4'hF) m_flags[a[8:4]] = 1'b1;
    check("snes_flags", valid_flags, m_flags);
    check("snes_wr_cnt", wr_q.size(), 1);
    if (wr_q.size() == 1) check("snes_wr", wr_q[0], {a, d});
  endtask

  task automatic do_fetch(input logic [7:0] pbr, input logic [15:0] addr, input int snes_beat,
                          input logic [8:0] s_addr, input logic [7:0] s_data,
                          input int flush_beat, input string tag);
    logic [15:0] off, a16;
    logic [4:0]  ln;
    logic        inwin, hit, done, s_pend, s_used, f_used;
    logic [7:0]  exp_data, got;
    int cyc;
    off = addr - m_cbr;
    inwin = off < 16'd512;
    ln = off[8:4];
    hit = inwin && m_flags[ln];
    exp_q.delete();
    exp_wr_q.delete();
    if (!inwin) begin
      exp_q.push_back({pbr, addr});
    end else if (!hit) begin
      if (flush_beat >= 0) begin
        for (int k = 0; k <= flush_beat; k++) begin
          a16 = m_cbr + {7'd0, ln, 4'(k)};
          exp_q.push_back({pbr, a16});
          if (k < flush_beat) exp_wr_q.push_back({ln, 4'(k), bus_byte({pbr, a16})});
        end
        m_flags = 32'd0;
      end
      for (int k = 0; k < 16; k++) begin
        a16 = m_cbr + {7'd0, ln, 4'(k)};
        if (k == snes_beat) begin
          exp_wr_q.push_back({s_addr, s_data});
          m_cache[s_addr] = s_data;
          if (s_addr[3:0] == 4'hF) m_flags[s_addr[8:4]] = 1'b1;
        end
        exp_q.push_back({pbr, a16});
        exp_wr_q.push_back({ln, 4'(k), bus_byte({pbr, a16})});
      end
      for (int k = 0; k < 16; k++) begin
        a16 = m_cbr + {7'd0, ln, 4'(k)};
        m_cache[{ln, 4'(k)}] = bus_byte({pbr, a16});
      end
      m_flags[ln] = 1'b1;
    end
    exp_data = inwin ? m_cache[off[8:0]] : bus_byte({pbr, addr});

    tick();
    obs_q.delete();
    wr_q.delete();
    fetch_pbr = pbr;
    fetch_addr = addr;
    fetch_req = 1'b1;
    acks = 0;
    cyc = 0;
    done = 1'b0;
    s_pend = 1'b0;
    s_used = 1'b0;
    f_used = 1'b0;
    got = 8'd0;
    while (!done && cyc < 3000) begin
      tick();
      cyc++;
      if (s_pend) begin
        snes_wr = 1'b1;
        snes_addr = s_addr;
        snes_data = s_data;
        s_pend = 1'b0;
      end
      if (snes_beat >= 0 && !s_used && mem_ack && acks == snes_beat + 1) begin
        s_pend = 1'b1;
        s_used = 1'b1;
      end
      if (flush_beat >= 0 && !f_used && mem_req && !mem_ack && acks == flush_beat) begin
        flush = 1'b1;
        f_used = 1'b1;
      end
      if (fetch_ack) begin
        done = 1'b1;
        got = fetch_data;
      end
    end
    fetch_req = 1'b0;
    check({tag, " ack_seen"}, done, 1'b1);
    check({tag, " data"}, got, exp_data);
    if (hit) check({tag, " hit_latency"}, cyc, 1);
    check({tag, " flags"}, valid_flags, m_flags);
    check({tag, " mem_cnt"}, obs_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size(); k++)
      check($sformatf("%s mem_addr[%0d]", tag, k), (k < obs_q.size()) ? obs_q[k] : 24'hxxxxxx, exp_q[k]);
    check({tag, " wr_cnt"}, wr_q.size(), exp_wr_q.size());
    for (int k = 0; k < exp_wr_q.size(); k++)
      check($sformatf("%s wr[%0d]", tag, k), (k < wr_q.size()) ? wr_q[k] : 17'hxxxxx, exp_wr_q[k]);
  endtask

  task automatic reset_mid_fill();
    logic [15:0] a16;
    logic [4:0]  ln;
    int cyc;
    ln = 5'h10;
    tick();
    fetch_pbr = 8'h03;
    fetch_addr = m_cbr + 16'h0100;
    fetch_req = 1'b1;
    acks = 0;
    cyc = 0;
    while (!(acks == 4 && mem_req && !mem_ack) && cyc < 500) begin
      tick();
      cyc++;
    end
    check("rstfill reached_beat4", cyc < 500, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rstfill mem_req", mem_req, 1'b0);
    check("rstfill flags", valid_flags, 32'd0);
    check("rstfill cbr", cbr, 16'd0);
    check("rstfill cache_we", cache_we, 1'b0);
    for (int k = 0; k < 4; k++) begin
      a16 = m_cbr + {7'd0, ln, 4'(k)};
      m_cache[{ln, 4'(k)}] = bus_byte({8'h03, a16});
    end
    m_cbr = 16'd0;
    m_flags = 32'd0;
    tick();
    fetch_req = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check("rstfill state_idle", dbg_state, 3'd0);
    check("rstfill mem_req_after", mem_req, 1'b0);
    check("rstfill flags_after", valid_flags, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    cbr_in = 16'd0;
    cbr_we = 1'b0;
    flush = 1'b0;
    fetch_req = 1'b0;
    fetch_pbr = 8'd0;
    fetch_addr = 16'd0;
    mem_ack = 1'b0;
    mem_data = 8'd0;
    snes_wr = 1'b0;
    snes_addr = 9'd0;
    snes_data = 8'd0;
    m_flags = 32'd0;
    m_cbr = 16'd0;
    repeat (3) tick();
    check("rst cbr", cbr, 16'd0);
    check("rst flags", valid_flags, 32'd0);
    check("rst fetch_ack", fetch_ack, 1'b0);
    check("rst mem_req", mem_req, 1'b0);
    check("rst cache_we", cache_we, 1'b0);
    check("rst mem_addr", mem_addr, 24'd0);
    check("rst cache_raddr", cache_raddr, 9'd0);
    check("rst cache_waddr", cache_waddr, 9'd0);
    check("rst fetch_data", fetch_data, 8'd0);
    check("rst state", dbg_state, 3'd0);
    rst_n = 1'b1;

    ack_gap = 1;
    set_cbr(16'h8000);
    do_fetch(8'h00, 16'h8013, -1, 9'd0, 8'd0, -1, "cold_miss");
    do_fetch(8'h00, 16'h8014, -1, 9'd0, 8'd0, -1, "hit");
    do_fetch(8'h01, 16'h8200, -1, 9'd0, 8'd0, -1, "bypass");
    do_fetch(8'h00, 16'h8050, 0, 9'h05F, 8'hAA, -1, "snes_fwr");
    do_fetch(8'h00, 16'h8070, -1, 9'd0, 8'd0, 7, "flush_mid");
    set_cbr(16'hFFF7);
    do_fetch(8'h02, 16'h0005, -1, 9'd0, 8'd0, -1, "wrap");
    snes_write(9'h0AF, 8'h5C);
    do_fetch(8'h02, 16'h00AF, -1, 9'd0, 8'd0, -1, "snes_line_hit");
    reset_mid_fill();

    ack_gap = -1;
    for (int it = 0; it < 40; it++) begin
      int sel;
      sel = int'($urandom_range(0, 9));
      if (sel < 6)
        do_fetch(8'($urandom_range(0, 3)), m_cbr + 16'($urandom_range(0, 639)),
                 -1, 9'd0, 8'd0, -1, $sformatf("rnd%0d", it));
      else if (sel == 6) set_cbr(16'($urandom));
      else if (sel == 7) do_flush();
      else snes_write(9'($urandom_range(0, 511)), 8'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
